spi_flash_cmd_arbiter: RTL and testbench
========================================

# spi_flash_cmd_arbiter

Command sequencer and round-robin arbiter that shares one byte-level SPI master engine between `NREQ` requesters issuing serial-flash commands (RDID, READ, WREN, RDSR, …). Each granted request is expanded into a chip-select-framed byte sequence: opcode, optional 24-bit address, then `rd_len` dummy-TX/read bytes. Captured read bytes stream back to the granted requester. The block sits between flash-client logic and the SPI master engine, and owns the flash chip select.

## Interface
Parameters:
- `NREQ`, 2: number of requesters (2..4).
- `LEN_W`, 4: width of the read-length field; max read burst is 2^LEN_W−1 bytes.

Ports:
- `clk`  in  1  system clock; all logic on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `req`  in  NREQ  per-requester request level.
- `opcode`  in  8*NREQ  packed opcodes; requester i uses bits [8i+7:8i].
- `addr_en`  in  NREQ  requester i's command carries a 3-byte address.
- `addr`  in  24*NREQ  packed addresses, sent MSB byte first.
- `rd_len`  in  LEN_W*NREQ  packed read-byte counts; 0 means no read phase.
- `gnt`  out  NREQ  one-hot grant, held for the whole transaction.
- `rdata`  out  8  read byte.
- `rdata_valid`  out  1  one-cycle strobe qualifying `rdata`.
- `rdata_last`  out  1  asserted with the final `rdata_valid` of a transaction.
- `done`  out  1  one-cycle pulse at transaction end; `gnt` is still valid in that cycle.
- `spi_cs_n`  out  1  flash chip select, active low.
- `spi_start`  out  1  one-cycle pulse that launches one byte on the engine.
- `spi_tx`  out  8  byte to shift out; stable from `spi_start` until `spi_done`.
- `spi_done`  in  1  one-cycle pulse from the engine when the byte completes.
- `spi_rx`  in  8  byte shifted in; valid when `spi_done` is high.

## Operation
- Reset values:
  - `gnt` = 0, `spi_cs_n` = 1.
  - `spi_start`, `rdata_valid`, `rdata_last`, `done` = 0.
  - `rdata` = 0x00, `spi_tx` = 0x00.
  - Round-robin pointer = requester 0 has highest priority.
- FSM states: IDLE, CS_SETUP, OPCODE, ADDR, READ, CS_HOLD, DONE.
- IDLE: when any `req` bit is set, grant the first set bit at or above the pointer, wrapping around. Latch that requester's opcode, addr_en, addr and rd_len, then move to CS_SETUP.
- CS_SETUP: drive `spi_cs_n` low for one cycle, then go to OPCODE.
- OPCODE: pulse `spi_start` with `spi_tx` = opcode, then wait for `spi_done`.
  - If addr_en: go to ADDR.
  - Else if rd_len ≠ 0: go to READ.
  - Else: go to CS_HOLD.
- ADDR: send three bytes in order, addr[23:16], addr[15:8], addr[7:0]. Each byte waits for `spi_done` before the next `spi_start`. Use a 2-bit byte counter. After the third byte, go to READ if rd_len ≠ 0, else CS_HOLD.
- READ: send 0x00 per byte. On each `spi_done`:
  - register `spi_rx` onto `rdata` and pulse `rdata_valid` in the next cycle;
  - decrement the remaining count;
  - `rdata_last` accompanies the byte that brings the count to 0, then go to CS_HOLD.
- CS_HOLD: hold `spi_cs_n` low for one cycle, then go to DONE.
- DONE: pulse `done`, raise `spi_cs_n`, and set the pointer to the granted index + 1 (mod NREQ). Next cycle, clear `gnt` and return to IDLE.
- Changes on `req` or the command fields after grant are ignored; the command is latched at grant.
- Deasserting `req` mid-transaction does not abort it.
- `spi_done` arriving in any state other than OPCODE/ADDR/READ-wait is ignored.
- Reset asserted mid-transaction: all outputs return to reset values immediately (asynchronously), `spi_cs_n` goes high, and no `done` is issued.

## Timing
- Grant latency: `req` high in IDLE gives `gnt` on the next edge. `spi_cs_n` falls one cycle later.
- First `spi_start` comes one cycle after `spi_cs_n` falls.
- Each subsequent `spi_start` comes one cycle after the previous `spi_done`.
- `rdata_valid` comes one cycle after the corresponding `spi_done`.
- `done` comes two cycles after the last `spi_done`. `spi_cs_n` rises on the edge after `done`.
- Back-to-back transactions: at least one IDLE cycle between them, with `spi_cs_n` high for at least 2 cycles.

## Structure
- Shared package `spi_flash_pkg`:
  - state encoding constants;
  - opcode constants: RDID 0x9F, READ 0x03, WREN 0x06, RDSR 0x05;
  - the address byte count (3).
- One natural sub-module, `rr_arbiter`. It is parameterised by NREQ and takes `req`, the pointer and an update strobe; it returns a one-hot grant. Everything else stays in the top FSM.

## Test plan
- RDID: req0 with opcode 0x9F, addr_en=0, rd_len=3; engine model returns EF, 40, 18. Required: TX bytes 9F 00 00 00; `rdata` EF/40/18 with `rdata_last` on 18; one `done`; `spi_cs_n` low for exactly that frame.
- READ: req1 with 0x03, addr 0x012345, rd_len=2. Required: TX bytes 03 01 23 45 00 00, and two `rdata_valid` strobes.
- WREN: 0x06 with rd_len=0. Required: a single TX byte, no `rdata_valid`, and `done` two cycles after `spi_done`.
- Arbitration (NREQ=2): req0 and req1 both held high continuously. Required: grant order 0,1,0,1, with no overlap of `gnt` bits.
- Reset asserted during the second ADDR byte. Required: `spi_cs_n`=1 and `gnt`=0 immediately, with no `done`. After release, a new req0 is served with the pointer at 0.
- `req` dropped and `opcode` changed one cycle after grant. Required: the transaction completes using the latched opcode.

Source files
------------

// File: rtl/spi_flash_cmd_arbiter_pkg.sv
// Shared definitions for the SPI flash command arbiter: FSM states, flash opcodes, address framing.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package spi_flash_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_CS_SETUP = 3'd1,
      ST_OPCODE   = 3'd2,
      ST_ADDR     = 3'd3,
      ST_READ     = 3'd4,
      ST_CS_HOLD  = 3'd5,
      ST_DONE     = 3'd6
   } state_t;

   localparam logic [7:0] OP_RDID = 8'h9F;
   localparam logic [7:0] OP_READ = 8'h03;
   localparam logic [7:0] OP_WREN = 8'h06;
   localparam logic [7:0] OP_RDSR = 8'h05;

   localparam int ADDR_BYTES = 3;

   // Address byte n of a 24-bit flash address, MSB byte first.
   function automatic logic [7:0] addr_byte(input logic [23:0] a, input logic [1:0] n);
      case (n)
         2'd0:    addr_byte = a[23:16];
         2'd1:    addr_byte = a[15:8];
         default: addr_byte = a[7:0];
      endcase
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or above the pointer, wrapping.
// Latency: combinational; grant is all-zero whenever upd is low.
// Backpressure: none; ports are req, ptr (highest-priority index), upd (evaluate strobe), gnt.
module rr_arbiter #(
   parameter int NREQ = 2,
   parameter int PW   = 1
) (
   input  logic [NREQ-1:0] req,
   input  logic [PW-1:0]   ptr,
   input  logic            upd,
   output logic [NREQ-1:0] gnt
);

   logic [2*NREQ-1:0] req_dbl;
   logic [2*NREQ-1:0] oh_dbl;
   logic [NREQ-1:0]   rot;
   logic [NREQ-1:0]   oh;
   logic              found;

   // Rotate requests so the pointer lands on bit 0, take the lowest set bit,
   // then rotate the one-hot back into requester order.
   always_comb begin
      req_dbl = {req, req} >> ptr;
      rot     = req_dbl[NREQ-1:0];
      oh      = '0;
      found   = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         if (rot[i] && !found) begin
            oh[i] = 1'b1;
            found = 1'b1;
         end
      end
      oh_dbl = {oh, oh} << ptr;
      gnt    = upd ? oh_dbl[2*NREQ-1:NREQ] : '0;
   end

endmodule

// File: rtl/spi_flash_cmd_arbiter.sv
// Shares one byte-level SPI engine among NREQ flash clients; frames opcode/addr/read bytes under CS.
// Latency: gnt 1 cycle after req; first spi_start 3 cycles after req; done 2 cycles after last spi_done.
// Backpressure: each byte waits for spi_done before the next spi_start; req is held off until done.
// Ports: req/opcode/addr_en/addr/rd_len per requester in; gnt, rdata/rdata_valid/rdata_last, done out;
//        spi_cs_n/spi_start/spi_tx to the engine, spi_done/spi_rx back from it.
module spi_flash_cmd_arbiter
   import spi_flash_pkg::*;
#(
   parameter int NREQ  = 2,
   parameter int LEN_W = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NREQ-1:0]       req,
   input  logic [8*NREQ-1:0]     opcode,
   input  logic [NREQ-1:0]       addr_en,
   input  logic [24*NREQ-1:0]    addr,
   input  logic [LEN_W*NREQ-1:0] rd_len,
   output logic [NREQ-1:0]       gnt,
   output logic [7:0]            rdata,
   output logic                  rdata_valid,
   output logic                  rdata_last,
   output logic                  done,
   output logic                  spi_cs_n,
   output logic                  spi_start,
   output logic [7:0]            spi_tx,
   input  logic                  spi_done,
   input  logic [7:0]            spi_rx
);

   localparam int PW = (NREQ > 2) ? 2 : 1;

   state_t           state;
   logic [PW-1:0]    ptr;
   logic [PW-1:0]    cur_idx;
   logic [7:0]       cmd_op;
   logic             cmd_ae;
   logic [23:0]      cmd_addr;
   logic [LEN_W-1:0] remain;
   logic [1:0]       ab_cnt;
   // Set once a byte has been launched; spi_done is only honoured while set.
   logic             wait_done;

   logic [NREQ-1:0]  arb_gnt;
   logic [PW-1:0]    sel;
   logic [7:0]       sel_op;
   logic             sel_ae;
   logic [23:0]      sel_addr;
   logic [LEN_W-1:0] sel_len;

   rr_arbiter #(
      .NREQ (NREQ),
      .PW   (PW)
   ) u_arb (
      .req  (req),
      .ptr  (ptr),
      .upd  (state == ST_IDLE),
      .gnt  (arb_gnt)
   );

   // Pick out the winning requester's command fields for latching.
   always_comb begin
      sel      = '0;
      sel_op   = '0;
      sel_ae   = 1'b0;
      sel_addr = '0;
      sel_len  = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (arb_gnt[i]) begin
            sel      = PW'(i);
            sel_op   = opcode[8*i +: 8];
            sel_ae   = addr_en[i];
            sel_addr = addr[24*i +: 24];
            sel_len  = rd_len[LEN_W*i +: LEN_W];
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= ST_IDLE;
         ptr         <= '0;
         cur_idx     <= '0;
         cmd_op      <= '0;
         cmd_ae      <= 1'b0;
         cmd_addr    <= '0;
         remain      <= '0;
         ab_cnt      <= '0;
         wait_done   <= 1'b0;
         gnt         <= '0;
         rdata       <= 8'h00;
         rdata_valid <= 1'b0;
         rdata_last  <= 1'b0;
         done        <= 1'b0;
         spi_cs_n    <= 1'b1;
         spi_start   <= 1'b0;
         spi_tx      <= 8'h00;
      end else begin
         spi_start   <= 1'b0;
         rdata_valid <= 1'b0;
         rdata_last  <= 1'b0;
         done        <= 1'b0;

         case (state)
            ST_IDLE: begin
               wait_done <= 1'b0;
               if (|arb_gnt) begin
                  gnt      <= arb_gnt;
                  cur_idx  <= sel;
                  cmd_op   <= sel_op;
                  cmd_ae   <= sel_ae;
                  cmd_addr <= sel_addr;
                  remain   <= sel_len;
                  state    <= ST_CS_SETUP;
               end
            end

            ST_CS_SETUP: begin
               spi_cs_n <= 1'b0;
               state    <= ST_OPCODE;
            end

            ST_OPCODE: begin
               if (!wait_done) begin
                  spi_start <= 1'b1;
                  spi_tx    <= cmd_op;
                  wait_done <= 1'b1;
               end else if (spi_done) begin
                  // Next byte launches on the same edge that retires this one.
                  if (cmd_ae) begin
                     spi_start <= 1'b1;
                     spi_tx    <= addr_byte(cmd_addr, 2'd0);
                     ab_cnt    <= 2'd0;
                     state     <= ST_ADDR;
                  end else if (remain != '0) begin
                     spi_start <= 1'b1;
                     spi_tx    <= 8'h00;
                     state     <= ST_READ;
                  end else begin
                     wait_done <= 1'b0;
                     state     <= ST_CS_HOLD;
                  end
               end
            end

            ST_ADDR: begin
               if (spi_done) begin
                  if (ab_cnt == 2'(ADDR_BYTES - 1)) begin
                     if (remain != '0) begin
                        spi_start <= 1'b1;
                        spi_tx    <= 8'h00;
                        state     <= ST_READ;
                     end else begin
                        wait_done <= 1'b0;
                        state     <= ST_CS_HOLD;
                     end
                  end else begin
                     ab_cnt    <= ab_cnt + 2'd1;
                     spi_start <= 1'b1;
                     spi_tx    <= addr_byte(cmd_addr, ab_cnt + 2'd1);
                  end
               end
            end

            ST_READ: begin
               if (spi_done) begin
                  rdata       <= spi_rx;
                  rdata_valid <= 1'b1;
                  remain      <= remain - LEN_W'(1);
                  if (remain == LEN_W'(1)) begin
                     rdata_last <= 1'b1;
                     wait_done  <= 1'b0;
                     state      <= ST_CS_HOLD;
                  end else begin
                     spi_start <= 1'b1;
                     spi_tx    <= 8'h00;
                  end
               end
            end

            ST_CS_HOLD: begin
               done  <= 1'b1;
               state <= ST_DONE;
            end

            ST_DONE: begin
               spi_cs_n <= 1'b1;
               gnt      <= '0;
               ptr      <= PW'((int'(cur_idx) + 1) % NREQ);
               state    <= ST_IDLE;
            end

            default: begin
               spi_cs_n <= 1'b1;
               gnt      <= '0;
               state    <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_spi_flash_cmd_arbiter.sv
// Self-checking bench: randomized engine latency and commands against a rule-level reference model.
// Latency: n/a.
// Backpressure: the engine model answers each spi_start with spi_done 1..3 cycles later.
module tb_spi_flash_cmd_arbiter;
   import spi_flash_pkg::*;

   localparam int NREQ  = 2;
   localparam int LEN_W = 4;

   logic                  clk = 1'b0;
   logic                  reset;
   logic [NREQ-1:0]       req;
   logic [8*NREQ-1:0]     opcode;
   logic [NREQ-1:0]       addr_en;
   logic [24*NREQ-1:0]    addr;
   logic [LEN_W*NREQ-1:0] rd_len;
   logic [NREQ-1:0]       gnt;
   logic [7:0]            rdata;
   logic                  rdata_valid;
   logic                  rdata_last;
   logic                  done;
   logic                  spi_cs_n;
   logic                  spi_start;
   logic [7:0]            spi_tx;
   logic                  spi_done;
   logic [7:0]            spi_rx;

   spi_flash_cmd_arbiter #(.NREQ(NREQ), .LEN_W(LEN_W)) dut (
      .clk         (clk),
      .reset       (reset),
      .req         (req),
      .opcode      (opcode),
      .addr_en     (addr_en),
      .addr        (addr),
      .rd_len      (rd_len),
      .gnt         (gnt),
      .rdata       (rdata),
      .rdata_valid (rdata_valid),
      .rdata_last  (rdata_last),
      .done        (done),
      .spi_cs_n    (spi_cs_n),
      .spi_start   (spi_start),
      .spi_tx      (spi_tx),
      .spi_done    (spi_done),
      .spi_rx      (spi_rx)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   always @(posedge clk) cyc++;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // ---------------- engine model (sole driver of spi_done/spi_rx) ----------------
   logic [7:0] tx_q[$];
   logic [7:0] rx_log[$];
   int         last_sdone_cyc = 0;
   int         cs_start_err   = 0;
   logic       preset_on      = 1'b0;
   int         preset_base    = 0;
   logic [7:0] preset_rx[4];

   initial begin
      int d;
      int bi;
      logic [7:0] b;
      spi_done = 1'b0;
      spi_rx   = 8'h00;
      forever begin
         @(negedge clk);
         while (spi_start && reset) begin
            tx_q.push_back(spi_tx);
            if (spi_cs_n) cs_start_err++;
            bi = tx_q.size() - 1;
            d  = $urandom_range(1, 3);
            repeat (d) @(negedge clk);
            if (preset_on && bi >= preset_base && bi < preset_base + 4)
               b = preset_rx[bi - preset_base];
            else
               b = 8'($urandom);
            spi_rx = b;
            rx_log.push_back(b);
            spi_done = 1'b1;
            last_sdone_cyc = cyc;
            @(negedge clk);
            spi_done = 1'b0;
         end
      end
   end

   // ---------------- output monitor ----------------
   logic [8:0] rd_q[$];
   int         done_total = 0;
   int         cs_err     = 0;
   int         ovl_err    = 0;

   always @(negedge clk) begin
      if (rdata_valid) rd_q.push_back({rdata_last, rdata});
      if (done) done_total++;
      if (!spi_cs_n && gnt == '0) cs_err++;
      if ($countones(gnt) > 1) ovl_err++;
   end

   // ---------------- reference model ----------------
   int               tb_ptr = 0;
   logic [7:0]       t_op[NREQ];
   logic             t_ae[NREQ];
   logic [23:0]      t_addr[NREQ];
   logic [LEN_W-1:0] t_len[NREQ];

   function automatic int pick(input logic [NREQ-1:0] m);
      for (int k = 0; k < NREQ; k++) begin
         int idx;
         idx = (tb_ptr + k) % NREQ;
         if (m[idx]) return idx;
      end
      return 0;
   endfunction

   task automatic load_fields();
      for (int i = 0; i < NREQ; i++) begin
         opcode[8*i +: 8]         = t_op[i];
         addr_en[i]               = t_ae[i];
         addr[24*i +: 24]         = t_addr[i];
         rd_len[LEN_W*i +: LEN_W] = t_len[i];
      end
   endtask

   task automatic wait_done_bounded(input string tag, output bit got);
      got = 1'b0;
      for (int k = 0; k < 400; k++) begin
         if (done) begin
            got = 1'b1;
            break;
         end
         @(negedge clk);
      end
      chk({tag, "_done_seen"}, 32'(got), 32'd1);
   endtask

   // One transaction: raise req on mask, then check framing, bytes and timing against the model.
   task automatic run_txn(input logic [NREQ-1:0] mask, input string tag);
      int         w, hdr, dcyc, tx_base, rd_base, done_base, n;
      bit         got;
      logic [7:0] exp_tx[$];

      w = pick(mask);
      exp_tx = {};
      exp_tx.push_back(t_op[w]);
      if (t_ae[w]) begin
         exp_tx.push_back(t_addr[w][23:16]);
         exp_tx.push_back(t_addr[w][15:8]);
         exp_tx.push_back(t_addr[w][7:0]);
      end
      n = int'(t_len[w]);
      repeat (n) exp_tx.push_back(8'h00);
      hdr = t_ae[w] ? 4 : 1;

      load_fields();
      tx_base   = tx_q.size();
      rd_base   = rd_q.size();
      done_base = done_total;
      req = mask;
      @(negedge clk);
      chk({tag, "_gnt"}, 32'(gnt), 32'(1 << w));
      chk({tag, "_cs_before"}, 32'(spi_cs_n), 32'd1);
      // Command inputs change right after grant; the latched copy must be used.
      req = '0;
      opcode[8*w +: 8]         = ~t_op[w];
      addr_en[w]               = ~t_ae[w];
      addr[24*w +: 24]         = ~t_addr[w];
      rd_len[LEN_W*w +: LEN_W] = ~t_len[w];
      @(negedge clk);
      chk({tag, "_cs_fall"}, 32'(spi_cs_n), 32'd0);
      @(negedge clk);
      chk({tag, "_start1"}, 32'(spi_start), 32'd1);
      chk({tag, "_tx_op"}, 32'(spi_tx), 32'(t_op[w]));

      wait_done_bounded(tag, got);
      if (!got) return;
      dcyc = cyc;
      chk({tag, "_done_gnt"}, 32'(gnt), 32'(1 << w));
      chk({tag, "_done_lat"}, 32'(dcyc - last_sdone_cyc), 32'd2);
      @(negedge clk);
      chk({tag, "_cs_rise"}, 32'(spi_cs_n), 32'd1);
      chk({tag, "_gnt_clr"}, 32'(gnt), 32'd0);
      chk({tag, "_done_cnt"}, 32'(done_total - done_base), 32'd1);

      chk({tag, "_tx_cnt"}, 32'(tx_q.size() - tx_base), 32'(exp_tx.size()));
      for (int j = 0; j < exp_tx.size() && tx_base + j < tx_q.size(); j++)
         chk($sformatf("%s_tx%0d", tag, j), 32'(tx_q[tx_base + j]), 32'(exp_tx[j]));

      chk({tag, "_rd_cnt"}, 32'(rd_q.size() - rd_base), 32'(n));
      for (int j = 0; j < n && rd_base + j < rd_q.size() && tx_base + hdr + j < rx_log.size(); j++)
         chk($sformatf("%s_rd%0d", tag, j), 32'(rd_q[rd_base + j]),
             32'({(j == n - 1), rx_log[tx_base + hdr + j]}));

      tb_ptr = (w + 1) % NREQ;
   endtask

   initial begin
      int         w;
      bit         got;
      int         done_base;
      logic [8:0] rd_last;

      reset   = 1'b0;
      req     = '0;
      opcode  = '0;
      addr_en = '0;
      addr    = '0;
      rd_len  = '0;
      repeat (3) @(negedge clk);

      chk("rst_gnt",    32'(gnt),         32'd0);
      chk("rst_cs",     32'(spi_cs_n),    32'd1);
      chk("rst_start",  32'(spi_start),   32'd0);
      chk("rst_rvalid", 32'(rdata_valid), 32'd0);
      chk("rst_rlast",  32'(rdata_last),  32'd0);
      chk("rst_done",   32'(done),        32'd0);
      chk("rst_rdata",  32'(rdata),       32'd0);
      chk("rst_tx",     32'(spi_tx),      32'd0);
      reset = 1'b1;
      @(negedge clk);

      for (int i = 0; i < NREQ; i++) begin
         t_op[i] = OP_RDSR; t_ae[i] = 1'b0; t_addr[i] = '0; t_len[i] = '0;
      end

      // RDID with a known ID returned by the flash
      preset_rx[0] = 8'hFF; preset_rx[1] = 8'hEF; preset_rx[2] = 8'h40; preset_rx[3] = 8'h18;
      preset_base  = tx_q.size();
      preset_on    = 1'b1;
      t_op[0] = OP_RDID; t_ae[0] = 1'b0; t_len[0] = 4'd3;
      run_txn(2'b01, "rdid");
      preset_on = 1'b0;
      rd_last = (rd_q.size() > 0) ? rd_q[rd_q.size() - 1] : 9'h0;
      chk("rdid_id_last", 32'(rd_last), 32'h118);

      // READ from requester 1 with a 24-bit address
      t_op[1] = OP_READ; t_ae[1] = 1'b1; t_addr[1] = 24'h012345; t_len[1] = 4'd2;
      run_txn(2'b10, "read");

      // Both requesters held high: grants must alternate
      for (int i = 0; i < NREQ; i++) begin
         t_op[i] = OP_RDSR; t_ae[i] = 1'b0; t_len[i] = 4'd1;
      end
      load_fields();
      req = '1;
      for (int t = 0; t < 4; t++) begin
         got = 1'b0;
         for (int k = 0; k < 50; k++) begin
            if (gnt != '0) begin
               got = 1'b1;
               break;
            end
            @(negedge clk);
         end
         chk($sformatf("arb%0d_seen", t), 32'(got), 32'd1);
         w = pick('1);
         chk($sformatf("arb%0d_gnt", t), 32'(gnt), 32'(1 << w));
         wait_done_bounded($sformatf("arb%0d", t), got);
         if (t == 3) req = '0;
         tb_ptr = (w + 1) % NREQ;
         @(negedge clk);
      end
      repeat (3) @(negedge clk);

      // WREN: opcode only
      t_op[0] = OP_WREN; t_ae[0] = 1'b0; t_len[0] = 4'd0;
      run_txn(2'b01, "wren");

      // Reset during the second address byte; pointer is 1 going in
      t_op[0] = OP_READ; t_ae[0] = 1'b1; t_addr[0] = 24'($urandom); t_len[0] = 4'd2;
      load_fields();
      done_base = done_total;
      begin
         int tx_base;
         tx_base = tx_q.size();
         req = 2'b01;
         @(negedge clk);
         req = '0;
         got = 1'b0;
         for (int k = 0; k < 100; k++) begin
            if (tx_q.size() - tx_base >= 3) begin
               got = 1'b1;
               break;
            end
            @(negedge clk);
         end
      end
      chk("mid_rst_reach", 32'(got), 32'd1);
      #1 reset = 1'b0;
      #1;
      chk("mid_rst_cs",    32'(spi_cs_n),  32'd1);
      chk("mid_rst_gnt",   32'(gnt),       32'd0);
      chk("mid_rst_start", 32'(spi_start), 32'd0);
      repeat (4) @(negedge clk);
      reset  = 1'b1;
      tb_ptr = 0;
      repeat (6) @(negedge clk);
      chk("mid_rst_nodone", 32'(done_total - done_base), 32'd0);
      t_op[0] = OP_RDSR; t_ae[0] = 1'b0; t_len[0] = 4'd1;
      t_op[1] = OP_READ; t_ae[1] = 1'b1; t_addr[1] = 24'hABCDEF; t_len[1] = 4'd1;
      run_txn(2'b11, "post_rst");

      // Randomized commands and request masks
      for (int t = 0; t < 20; t++) begin
         for (int i = 0; i < NREQ; i++) begin
            t_op[i]   = 8'($urandom);
            t_ae[i]   = 1'($urandom);
            t_addr[i] = 24'($urandom);
            t_len[i]  = LEN_W'($urandom);
         end
         run_txn(NREQ'($urandom_range(1, (1 << NREQ) - 1)), $sformatf("rnd%0d", t));
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      chk("gnt_overlap", 32'(ovl_err),      32'd0);
      chk("cs_no_gnt",   32'(cs_err),       32'd0);
      chk("cs_at_start", 32'(cs_start_err), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
      $fatal(1, "watchdog");
   end

endmodule
